tokenizer_engine: RTL and testbench

- Stage directly downstream of the button/start controller: consumes its one-cycle START pulse plus the STR_ADDR/OUT_ADDR pointers, and drives IDLE back to it.
- Reads a zero-terminated ASCII string from memory via a simple word-read port and splits it into space-separated tokens.
- Writes one descriptor word per token to the output buffer, then an end marker, then returns to idle.

---
 rtl/tokenizer_pkg.sv | 23 ++
 rtl/tok_byte_classifier.sv | 23 ++
 rtl/tokenizer_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_tokenizer_engine.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tokenizer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tokenizer_pkg
// Purpose  : Shared types and constants for the string tokenizer engine.
// Revision : 1.0 - initial release
// ============================================================================
package tokenizer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_SCAN    = 3'd3,
    S_WR      = 3'd4,
    S_WR_END  = 3'd5
  } state_t;

  localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;
  localparam logic [7:0]  SEP_CHAR   = 8'h20;
  localparam logic [7:0]  TERM_CHAR  = 8'h00;

endpackage
`default_nettype wire

// File: rtl/tok_byte_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tok_byte_classifier
// Purpose  : Combinational classification of one ASCII byte as string
//            terminator or token separator.
// Revision : 1.0 - initial release
// ============================================================================
module tok_byte_classifier
  import tokenizer_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_term,
  output logic       is_sep
);

  // Compare the byte against the two special characters.
  always_comb begin
    is_term = (ch == TERM_CHAR);
    is_sep  = (ch == SEP_CHAR);
  end

endmodule
`default_nettype wire

// File: rtl/tokenizer_engine.sv
`default_nettype none
// ============================================================================
// Module   : tokenizer_engine
// Purpose  : Reads a zero-terminated string word by word, splits it into
//            space-separated tokens and writes one {start,len} descriptor per
//            token followed by an end marker.
// Revision : 1.0 - initial release
// ============================================================================
module tokenizer_engine
  import tokenizer_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_BYTES      = 4096
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      START,
  input  logic [AXI_ADDR_WIDTH-1:0] STR_ADDR,
  input  logic [AXI_ADDR_WIDTH-1:0] OUT_ADDR,
  output logic                      IDLE,
  output logic                      rd_addr_valid,
  input  logic                      rd_addr_ready,
  output logic [AXI_ADDR_WIDTH-1:0] rd_addr,
  input  logic                      rd_data_valid,
  input  logic [31:0]               rd_data,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [AXI_ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]               wr_data,
  output logic [15:0]               TOKEN_COUNT,
  output logic                      ERROR
);

  // Offset of the final byte allowed in one run; fits 16 bits for MAX_BYTES <= 65536.
  localparam logic [15:0] LAST_OFF = 16'(MAX_BYTES - 1);

  state_t                      state, state_n;
  logic [AXI_ADDR_WIDTH-1:0]   str_ptr, str_ptr_n;
  logic [AXI_ADDR_WIDTH-1:0]   out_ptr, out_ptr_n;
  logic [31:0]                 word, word_n;
  logic [1:0]                  lane, lane_n;
  logic [15:0]                 byte_off, byte_off_n;
  logic [15:0]                 tok_start, tok_start_n;
  logic [15:0]                 tok_len, tok_len_n;
  logic [15:0]                 token_count, token_count_n;
  logic                        in_tok, in_tok_n;
  logic                        error, error_n;
  // Set when the pending descriptor closes the run (terminator or byte limit).
  logic                        term_emit, term_emit_n;

  logic [7:0]                  cur_byte;
  logic                        is_term, is_sep;
  logic                        last_byte;
  logic [15:0]                 run_start;

  assign cur_byte    = word[{lane, 3'b000} +: 8];
  assign last_byte   = (byte_off == LAST_OFF);
  assign run_start   = in_tok ? tok_start : byte_off;
  assign IDLE        = (state == S_IDLE) && !START;
  assign TOKEN_COUNT = token_count;
  assign ERROR       = error;

  tok_byte_classifier u_classifier (
    .ch      (cur_byte),
    .is_term (is_term),
    .is_sep  (is_sep)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      str_ptr     <= '0;
      out_ptr     <= '0;
      word        <= '0;
      lane        <= '0;
      byte_off    <= '0;
      tok_start   <= '0;
      tok_len     <= '0;
      token_count <= '0;
      in_tok      <= 1'b0;
      error       <= 1'b0;
      term_emit   <= 1'b0;
    end else begin
      str_ptr     <= str_ptr_n;
      out_ptr     <= out_ptr_n;
      word        <= word_n;
      lane        <= lane_n;
      byte_off    <= byte_off_n;
      tok_start   <= tok_start_n;
      tok_len     <= tok_len_n;
      token_count <= token_count_n;
      in_tok      <= in_tok_n;
      error       <= error_n;
      term_emit   <= term_emit_n;
    end
  end

  // Next-state, next-datapath and bus outputs.
  always_comb begin
    state_n       = state;
    str_ptr_n     = str_ptr;
    out_ptr_n     = out_ptr;
    word_n        = word;
    lane_n        = lane;
    byte_off_n    = byte_off;
    tok_start_n   = tok_start;
    tok_len_n     = tok_len;
    token_count_n = token_count;
    in_tok_n      = in_tok;
    error_n       = error;
    term_emit_n   = term_emit;
    rd_addr_valid = 1'b0;
    rd_addr       = '0;
    wr_valid      = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;

    case (state)
      S_IDLE: begin
        if (START) begin
          str_ptr_n     = STR_ADDR;
          out_ptr_n     = OUT_ADDR;
          byte_off_n    = '0;
          token_count_n = '0;
          error_n       = 1'b0;
          in_tok_n      = 1'b0;
          state_n       = S_RD_ADDR;
        end
      end

      S_RD_ADDR: begin
        rd_addr_valid = 1'b1;
        rd_addr       = str_ptr;
        if (rd_addr_ready) state_n = S_RD_DATA;
      end

      S_RD_DATA: begin
        if (rd_data_valid) begin
          word_n    = rd_data;
          lane_n    = 2'd0;
          str_ptr_n = str_ptr + AXI_ADDR_WIDTH'(4);
          state_n   = S_SCAN;
        end
      end

      S_SCAN: begin
        byte_off_n = byte_off + 16'd1;
        if (last_byte && !is_term) error_n = 1'b1;
        if (is_term) begin
          if (in_tok) begin
            tok_len_n   = byte_off - tok_start;
            term_emit_n = 1'b1;
            in_tok_n    = 1'b0;
            state_n     = S_WR;
          end else begin
            state_n = S_WR_END;
          end
        end else if (is_sep) begin
          if (in_tok) begin
            tok_len_n   = byte_off - tok_start;
            term_emit_n = last_byte;
            in_tok_n    = 1'b0;
            state_n     = S_WR;
          end else if (last_byte) begin
            state_n = S_WR_END;
          end else begin
            lane_n  = lane + 2'd1;
            state_n = (lane == 2'd3) ? S_RD_ADDR : S_SCAN;
          end
        end else begin
          tok_start_n = run_start;
          in_tok_n    = 1'b1;
          if (last_byte) begin
            // The limit byte still belongs to the token, so it counts in the length.
            tok_len_n   = byte_off + 16'd1 - run_start;
            term_emit_n = 1'b1;
            in_tok_n    = 1'b0;
            state_n     = S_WR;
          end else begin
            lane_n  = lane + 2'd1;
            state_n = (lane == 2'd3) ? S_RD_ADDR : S_SCAN;
          end
        end
      end

      S_WR: begin
        wr_valid = 1'b1;
        wr_addr  = out_ptr;
        wr_data  = {tok_start, tok_len};
        if (wr_ready) begin
          out_ptr_n     = out_ptr + AXI_ADDR_WIDTH'(4);
          token_count_n = token_count + 16'd1;
          if (term_emit) begin
            state_n = S_WR_END;
          end else begin
            lane_n  = lane + 2'd1;
            state_n = (lane == 2'd3) ? S_RD_ADDR : S_SCAN;
          end
        end
      end

      S_WR_END: begin
        wr_valid = 1'b1;
        wr_addr  = out_ptr;
        wr_data  = END_MARKER;
        if (wr_ready) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tokenizer_engine.sv
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tokenizer_engine
// Purpose  : Scoreboard bench for tokenizer_engine with a memory model,
//            randomised bus backpressure and a token-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tokenizer_engine;
  import tokenizer_pkg::*;

  localparam int AW   = 32;
  localparam int MAXB = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          START = 1'b0;
  logic [AW-1:0] STR_ADDR = '0;
  logic [AW-1:0] OUT_ADDR = '0;
  logic          IDLE;
  logic          rd_addr_valid;
  logic          rd_addr_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_data_valid;
  logic [31:0]   rd_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [15:0]   TOKEN_COUNT;
  logic          ERROR;

  tokenizer_engine #(.AXI_ADDR_WIDTH(AW), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .resetn(resetn), .START(START),
    .STR_ADDR(STR_ADDR), .OUT_ADDR(OUT_ADDR), .IDLE(IDLE),
    .rd_addr_valid(rd_addr_valid), .rd_addr_ready(rd_addr_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .TOKEN_COUNT(TOKEN_COUNT), .ERROR(ERROR)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef logic [7:0] bq_t [$];

  wr_t        exp_q [$];
  logic [7:0] mem [logic [31:0]];
  int         vectors = 0;
  int         miscompares = 0;
  int         max_stall = 0;
  bit         hold_wr = 1'b0;
  int         exp_tokens = 0;
  bit         exp_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Load string into memory, then derive expected writes from the token rules.
  task automatic load_and_expect(input logic [31:0] sa, input logic [31:0] oa, input bq_t s);
    int n;
    int k;
    int i;
    int st;
    for (int j = 0; j < MAXB + 8; j++) begin
      if (j < s.size())       mem[sa + 32'(j)] = s[j];
      else if (j == s.size()) mem[sa + 32'(j)] = 8'h00;
      else                    mem[sa + 32'(j)] = 8'($urandom);
    end
    n = MAXB;
    exp_err = 1'b1;
    for (int j = 0; j < MAXB; j++) begin
      if (mem[sa + 32'(j)] == 8'h00) begin
        n = j;
        exp_err = 1'b0;
        break;
      end
    end
    k = 0;
    i = 0;
    while (i < n) begin
      if (mem[sa + 32'(i)] == SEP_CHAR) begin
        i++;
      end else begin
        st = i;
        while (i < n && mem[sa + 32'(i)] != SEP_CHAR) i++;
        exp_q.push_back('{addr: oa + 32'(4 * k), data: {16'(st), 16'(i - st)}});
        k++;
      end
    end
    exp_q.push_back('{addr: oa + 32'(4 * k), data: END_MARKER});
    exp_tokens = k;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!IDLE && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!IDLE) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: engine still busy after %0d cycles, expected idle", n);
      pulse_reset();
    end
  endtask

  task automatic run(input logic [31:0] sa, input logic [31:0] oa, input bq_t s, input bit restart);
    load_and_expect(sa, oa, s);
    @(negedge clk);
    STR_ADDR = sa;
    OUT_ADDR = oa;
    START = 1'b1;
    #1 check("idle_drop", IDLE, 0);
    @(negedge clk);
    START = 1'b0;
    if (restart) begin
      repeat (3) @(negedge clk);
      check("busy_idle_low", IDLE, 0);
      STR_ADDR = sa + 32'h100;
      OUT_ADDR = oa + 32'h200;
      START = 1'b1;
      @(negedge clk);
      START = 1'b0;
    end
    wait_idle();
    check("token_count", TOKEN_COUNT, exp_tokens);
    check("error_flag", ERROR, exp_err);
    check("writes_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Hold off a descriptor write, then reset in the middle of it.
  task automatic reset_mid_write();
    int n = 0;
    hold_wr = 1'b1;
    load_and_expect(32'hC000_0000, 32'hC000_0100, str2q("ab cd"));
    @(negedge clk);
    STR_ADDR = 32'hC000_0000;
    OUT_ADDR = 32'hC000_0100;
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    while (!(wr_valid && wr_data != END_MARKER) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_wr", wr_valid, 1);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_idle", IDLE, 1);
    check("rst_rd_valid", rd_addr_valid, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_count", TOKEN_COUNT, 0);
    check("rst_error", ERROR, 0);
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    hold_wr = 1'b0;
  endtask

  // Read port responder: random accept stalls, random data latency, stray beats.
  initial begin : rd_resp
    bit          pend = 1'b0;
    logic [31:0] paddr = '0;
    int          pdel = 0;
    int          stall = 0;
    bit          stalled = 1'b0;
    logic [31:0] saddr = '0;
    rd_addr_ready = 1'b0;
    rd_data_valid = 1'b0;
    rd_data = '0;
    forever begin
      @(negedge clk);
      rd_addr_ready = 1'b0;
      rd_data_valid = 1'b0;
      rd_data = $urandom;
      if (!resetn) begin
        pend = 1'b0;
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        check("rd_hold_valid", rd_addr_valid, 1);
        check("rd_hold_addr", rd_addr, saddr);
      end
      stalled = 1'b0;
      if (pend) begin
        if (pdel == 0) begin
          rd_data_valid = 1'b1;
          rd_data = {mem[paddr + 3], mem[paddr + 2], mem[paddr + 1], mem[paddr]};
          pend = 1'b0;
        end else begin
          pdel--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        rd_data_valid = 1'b1;
      end
      if (rd_addr_valid && !pend) begin
        if (stall > 0) begin
          stall--;
          stalled = 1'b1;
          saddr = rd_addr;
        end else begin
          rd_addr_ready = 1'b1;
          pend = 1'b1;
          paddr = rd_addr;
          pdel = $urandom_range(0, 3);
          stall = $urandom_range(0, max_stall);
        end
      end
    end
  end

  // Write port monitor: random stalls, scoreboard pop on each accepted write.
  initial begin : wr_mon
    int          stall = 0;
    bit          stalled = 1'b0;
    logic [31:0] sa = '0;
    logic [31:0] sd = '0;
    wr_t         e;
    wr_ready = 1'b0;
    forever begin
      @(negedge clk);
      wr_ready = 1'b0;
      if (!resetn) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        check("wr_hold_valid", wr_valid, 1);
        check("wr_hold_addr", wr_addr, sa);
        check("wr_hold_data", wr_data, sd);
      end
      stalled = 1'b0;
      if (wr_valid) begin
        if (hold_wr || stall > 0) begin
          if (stall > 0) stall--;
          stalled = 1'b1;
          sa = wr_addr;
          sd = wr_data;
        end else begin
          wr_ready = 1'b1;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL wr_unexpected: write %0h to %0h, expected no write", wr_data, wr_addr);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", wr_addr, e.addr);
            check("wr_data", wr_data, e.data);
          end
          stall = $urandom_range(0, max_stall);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bq_t         q;
    logic [31:0] sa;
    logic [31:0] oa;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_idle", IDLE, 1);
    check("reset_rd_valid", rd_addr_valid, 0);
    check("reset_wr_valid", wr_valid, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", wr_data, 0);
    check("reset_count", TOKEN_COUNT, 0);
    check("reset_error", ERROR, 0);
    resetn = 1'b1;
    @(negedge clk);

    max_stall = 0;
    run(32'hC000_0000, 32'hC000_0100, str2q("ab cd"), 1'b0);
    run(32'hC000_0000, 32'hC000_0100, str2q("  x  "), 1'b0);
    run(32'hC000_0000, 32'hC000_0100, str2q(""), 1'b0);
    max_stall = 5;
    run(32'hC000_0040, 32'hC000_0200, str2q("hello world"), 1'b1);
    run(32'hC000_0080, 32'hC000_0300, str2q("abcdefghijklmnop"), 1'b0);
    run(32'hC000_0080, 32'hC000_0300, str2q("abcdefghijklmno "), 1'b0);
    reset_mid_write();

    for (int r = 0; r < 40; r++) begin
      q.delete();
      for (int j = 0; j < int'($urandom_range(0, 20)); j++)
        q.push_back(($urandom_range(0, 2) == 0) ? SEP_CHAR : 8'(8'h61 + 8'($urandom_range(0, 25))));
      sa = 32'h1000_0000 + 32'($urandom_range(0, 63) * 64);
      oa = 32'h2000_0000 + 32'($urandom_range(0, 63) * 128);
      max_stall = $urandom_range(0, 5);
      run(sa, oa, q, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
